// File: rtl/uart_tx_buf.sv
// uart_tx_buf: buffered 8N1 UART transmitter; bytes are queued in a small FIFO and shifted out LSB first, timed by the oversample tick.
// Ports: clk/rst (sync, active-high), tick (oversample pulse), txEn (gates frame starts),
//        txWr/txData (FIFO push), uart_tx (serial line, idle high), txBusy (frame in flight),
//        txFull/txEmpty (registered FIFO flags), txDone (one-clk pulse at end of last stop bit).
// Optional: define UART_TX_PARITY_EN to add a parity bit and the parOdd input (1 = odd parity).
module uart_tx_buf #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 txEn,
  input  logic                 txWr,
  input  logic [DATA_BITS-1:0] txData,
`ifdef UART_TX_PARITY_EN
  input  logic                 parOdd,
`endif
  output logic                 uart_tx,
  output logic                 txBusy,
  output logic                 txFull,
  output logic                 txEmpty,
  output logic                 txDone
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2((DATA_BITS > STOP_BITS ? DATA_BITS : STOP_BITS) + 1);
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wp, r_rp;
  logic [AW:0]          r_cnt;
  logic [TW-1:0]        r_tcnt;
  logic [BW-1:0]        r_bcnt;
  logic [DATA_BITS-1:0] r_shift;
  state_t               r_state;
`ifdef UART_TX_PARITY_EN
  logic                 r_par;
`endif
  logic                 w_push, w_pop, w_bit_end;
  logic [AW:0]          w_cnt_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  // a write while full is dropped outright, even if a pop frees a slot this cycle
  assign w_push      = txWr && !txFull;
  assign w_pop       = r_state == S_IDLE && txEn && !txEmpty;
  assign w_bit_end   = tick && r_tcnt == TW'(OVERSAMPLE - 1);
  assign w_cnt_nxt   = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_shift_nxt = r_shift >> 1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      txFull  <= 1'b0;
      txEmpty <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= txData;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt   <= w_cnt_nxt;
      txFull  <= w_cnt_nxt == (AW+1)'(FIFO_DEPTH);
      txEmpty <= w_cnt_nxt == '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      uart_tx <= 1'b1;
      txBusy  <= 1'b0;
      txDone  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      txDone <= 1'b0;
      // ticks are only counted once a frame is running; the tick on the start edge is ignored
      if (r_state != S_IDLE && tick) r_tcnt <= w_bit_end ? '0 : r_tcnt + TW'(1);
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_shift <= r_mem[r_rp];
          r_tcnt  <= '0;
          r_bcnt  <= '0;
          r_state <= S_START;
          uart_tx <= 1'b0;
          txBusy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
          r_par   <= ^r_mem[r_rp];
`endif
        end
        S_START: if (w_bit_end) begin
          r_state <= S_DATA;
          uart_tx <= r_shift[0];
        end
        S_DATA: if (w_bit_end) begin
          r_shift <= w_shift_nxt;
          if (r_bcnt == BW'(DATA_BITS - 1)) begin
            r_bcnt  <= '0;
`ifdef UART_TX_PARITY_EN
            r_state <= S_PARITY;
            uart_tx <= r_par ^ parOdd;
`else
            r_state <= S_STOP;
            uart_tx <= 1'b1;
`endif
          end else begin
            r_bcnt  <= r_bcnt + BW'(1);
            uart_tx <= w_shift_nxt[0];
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: if (w_bit_end) begin
          r_state <= S_STOP;
          uart_tx <= 1'b1;
        end
`endif
        S_STOP: if (w_bit_end) begin
          if (r_bcnt == BW'(STOP_BITS - 1)) begin
            r_bcnt  <= '0;
            r_state <= S_IDLE;
            txBusy  <= 1'b0;
            txDone  <= 1'b1;
          end else r_bcnt <= r_bcnt + BW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: directed and randomized checks of uart_tx_buf against a tick-counting frame model.
module tb_uart_tx_buf;
  localparam int OS = 16;
  localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int L = 1 + 8 + PB + SB;
  logic       clk = 0, rst = 1, tick = 0, txEn = 0, txWr = 0;
  logic [7:0] txData = 0;
`ifdef UART_TX_PARITY_EN
  logic       parOdd = 0;
`endif
  logic       uart_tx, txBusy, txFull, txEmpty, txDone;
  int         n_assert = 0, n_fail = 0, done_cnt = 0, exp_done = 0, tper = 4;
  uart_tx_buf dut (
    .clk(clk), .rst(rst), .tick(tick), .txEn(txEn), .txWr(txWr), .txData(txData),
`ifdef UART_TX_PARITY_EN
    .parOdd(parOdd),
`endif
    .uart_tx(uart_tx), .txBusy(txBusy), .txFull(txFull), .txEmpty(txEmpty), .txDone(txDone)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (txDone === 1'b1) done_cnt <= done_cnt + 1;
  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      c++;
      if (c >= tper) begin
        tick = 1;
        c = 0;
      end else tick = 0;
    end
  end
  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return (^b) ^ parOdd;
`endif
    return 1'b1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    txWr = 1;
    txData = d;
  endtask
  task automatic wr_end();
    @(negedge clk);
    txWr = 0;
  endtask
  task automatic wait_cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic check_frame(input logic [7:0] b, input bit drop, input int lim);
    int t = 0, n = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (uart_tx !== 1'b0 && t < 5000);
    chk($sformatf("start_fall_%02h", b), uart_tx, 0);
    if (uart_tx !== 1'b0) return;
    chk("busy_start", txBusy, 1);
    if (drop) txEn = 0;
    t = 0;
    while (n < lim && t < 20000) begin
      @(posedge clk);
      t++;
      if (tick) begin
        n++;
        #1;
        if (n % OS == 0 || n % OS == OS - 1)
          chk($sformatf("b%02h_bit%0d_t%0d", b, n / OS, n), uart_tx, exp_bit(b, n / OS));
        if (n == L * OS) begin
          chk("done_pulse", txDone, 1);
          chk("busy_end", txBusy, 0);
        end else if (n % OS == 0) chk("no_early_done", txDone, 0);
      end
    end
    chk("frame_ticks", n, lim);
  endtask
  initial begin
    logic [7:0] rnd [5];
    logic [7:0] q[$];
    logic [7:0] b1, b2;
    int k;
    wait_cyc(3);
    chk("rst_tx", uart_tx, 1);
    chk("rst_busy", txBusy, 0);
    chk("rst_done", txDone, 0);
    chk("rst_empty", txEmpty, 1);
    chk("rst_full", txFull, 0);
    rst = 0;
    @(negedge clk);
    txEn = 1;
    wr(8'h55);
    wr_end();
    check_frame(8'h55, 0, L * OS);
    exp_done++;
    wait_cyc(2);
    chk("done_cnt_55", done_cnt, exp_done);
    chk("busy_after_55", txBusy, 0);
    chk("done_one_clk", txDone, 0);
    fork
      begin
        wr(8'hA3);
        wr(8'h0F);
        wr(8'hFF);
        wr_end();
      end
      begin
        check_frame(8'hA3, 0, L * OS);
        check_frame(8'h0F, 0, L * OS);
        check_frame(8'hFF, 0, L * OS);
      end
    join
    exp_done += 3;
    wait_cyc(2);
    chk("done_cnt_b2b", done_cnt, exp_done);
    chk("empty_b2b", txEmpty, 1);
    @(negedge clk);
    txEn = 0;
    for (int i = 0; i < 5; i++) begin
      rnd[i] = 8'($urandom);
      if (q.size() < 4) q.push_back(rnd[i]);
    end
    for (int i = 0; i < 4; i++) wr(rnd[i]);
    wr_end();
    chk("full_after_4", txFull, 1);
    chk("not_empty_4", txEmpty, 0);
    wr(rnd[4]);
    wr_end();
    chk("full_after_5", txFull, 1);
    wait_cyc(200);
    chk("idle_when_disabled", uart_tx, 1);
    chk("no_busy_disabled", txBusy, 0);
    txEn = 1;
    while (q.size() > 0) begin
      check_frame(q.pop_front(), 0, L * OS);
      exp_done++;
    end
    wait_cyc(1000);
    chk("done_cnt_full", done_cnt, exp_done);
    chk("empty_after_full", txEmpty, 1);
    chk("line_idle_full", uart_tx, 1);
    txEn = 0;
    wr(8'h81);
    wr(8'($urandom));
    wr_end();
    @(negedge clk);
    txEn = 1;
    check_frame(8'h81, 0, 4 * OS + 8);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("rst_mid_tx", uart_tx, 1);
    chk("rst_mid_busy", txBusy, 0);
    chk("rst_mid_empty", txEmpty, 1);
    chk("rst_mid_full", txFull, 0);
    @(negedge clk);
    rst = 0;
    wait_cyc(1000);
    chk("rst_no_done", done_cnt, exp_done);
    chk("rst_line_idle", uart_tx, 1);
    chk("rst_still_empty", txEmpty, 1);
    txEn = 0;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    wr(b1);
    wr(b2);
    wr_end();
    @(negedge clk);
    txEn = 1;
    check_frame(b1, 1, L * OS);
    exp_done++;
    wait_cyc(500);
    chk("drop_en_queued", txEmpty, 0);
    chk("drop_en_idle", uart_tx, 1);
    chk("drop_en_done", done_cnt, exp_done);
    txEn = 1;
    check_frame(b2, 0, L * OS);
    exp_done++;
    wait_cyc(2);
    chk("drop_en_empty", txEmpty, 1);
`ifdef UART_TX_PARITY_EN
    parOdd = 0;
    wr(8'h07);
    wr_end();
    check_frame(8'h07, 0, L * OS);
    wait_cyc(2);
    parOdd = 1;
    wr(8'h07);
    wr_end();
    check_frame(8'h07, 0, L * OS);
    exp_done += 2;
    wait_cyc(2);
    parOdd = 0;
`endif
    for (int r = 0; r < 3; r++) begin
      tper = int'($urandom_range(1, 5));
      k = int'($urandom_range(1, 4));
      for (int i = 0; i < k; i++) rnd[i] = 8'($urandom);
      wait_cyc(10);
      fork
        begin
          for (int i = 0; i < k; i++) wr(rnd[i]);
          wr_end();
        end
        begin
          for (int j = 0; j < k; j++) check_frame(rnd[j], 0, L * OS);
        end
      join
      exp_done += k;
      wait_cyc(3);
      chk($sformatf("rand%0d_done", r), done_cnt, exp_done);
      chk($sformatf("rand%0d_empty", r), txEmpty, 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
